trng_collector: RTL and testbench

TRNG_COLLECTOR -- requirements
Module: trng_collector

---
 rtl/trng_pkg.sv | 33 +++
 rtl/trng_health_rep.sv | 58 +++++
 rtl/trng_collector.sv | 166 ++++++++++++++++
 tb/tb_trng_collector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared FSM state encoding, default parameter values and a
//                counter-width helper for the TRNG collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAIL    = 3'd4
    } trng_state_t;

    localparam int DEF_OUT_W     = 128;
    localparam int DEF_NSRC      = 8;
    localparam int DEF_WARMUP    = 200;
    localparam int DEF_REP_LIMIT = 32;

    // Bits needed to hold 0..max_val; never narrower than one bit so a
    // zero-length phase still gets a legal counter.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trng_health_rep.sv
`default_nettype none
// ============================================================================
//  Module      : trng_health_rep
//  Description : Repetition-count health test. Tracks the run length of
//                identical raw bits while valid is high and flags a failure
//                in the same cycle the run reaches REP_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_health_rep
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    input  logic valid,
    input  logic clear,
    output logic fail
);

    localparam int RUN_W = cnt_width(REP_LIMIT);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             last_bit;

    // Run length including the current bit; a zero count means no history,
    // and the count saturates at the limit so it can never wrap.
    always_comb begin
        run_next = RUN_W'(1);
        if ((run_cnt != '0) && (bit_in == last_bit)) begin
            if (run_cnt == RUN_W'(REP_LIMIT)) begin
                run_next = run_cnt;
            end else begin
                run_next = run_cnt + 1'b1;
            end
        end
    end

    assign fail = valid && (run_next >= RUN_W'(REP_LIMIT));

    // Run history, restarted whenever a new request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (clear) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
        end else if (valid) begin
            run_cnt  <= run_next;
            last_bit <= bit_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trng_collector.sv
`default_nettype none
// ============================================================================
//  Module      : trng_collector
//  Description : Collects OUT_W random bits from NSRC ring-oscillator inputs.
//                Inputs are synchronised and XOR-folded into one raw bit,
//                discarded for WARMUP cycles, optionally von Neumann debiased
//                and shifted into a word, guarded by a repetition test.
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_collector
    import trng_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int NSRC      = DEF_NSRC,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             vn_en,
    input  logic [NSRC-1:0]  ent_in,
    output logic [OUT_W-1:0] rand_out,
    output logic             done,
    output logic             busy,
    output logic             fail
);

    localparam int CYC_W = cnt_width(WARMUP);
    localparam int BIT_W = cnt_width(OUT_W);

    trng_state_t      state;
    logic [NSRC-1:0]  sync1;
    logic [NSRC-1:0]  sync2;
    logic             raw_bit;
    logic [CYC_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    // Holds the OUT_W-1 bits gathered so far; the final bit joins them
    // directly on the way into rand_out.
    logic [OUT_W-2:0] partial;
    logic [OUT_W-1:0] shift_next;
    logic             vn_mode;
    logic             pair_phase;
    logic             pair_first;
    logic             start;
    logic             collecting;
    logic             accept;
    logic             acc_bit;
    logic             word_full;
    logic             health_fail;

    // Two-flop synchroniser on every asynchronous entropy input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ent_in;
            sync2 <= sync1;
        end
    end

    assign raw_bit    = ^sync2;
    assign start      = go && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
    assign collecting = (state == ST_COLLECT);

    // Bit acceptance: every raw bit in plain mode; in debias mode only the
    // second bit of an unequal pair, where the pair's first bit is the output.
    always_comb begin
        accept  = 1'b0;
        acc_bit = raw_bit;
        if (collecting) begin
            if (!vn_mode) begin
                accept = 1'b1;
            end else if (pair_phase && (pair_first != raw_bit)) begin
                accept  = 1'b1;
                acc_bit = pair_first;
            end
        end
    end

    assign shift_next = {acc_bit, partial};
    assign word_full  = accept && (bit_cnt == BIT_W'(OUT_W - 1));

    trng_health_rep #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health_rep (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit_in (raw_bit),
        .valid  (collecting),
        .clear  (start),
        .fail   (health_fail)
    );

    // Control FSM with registered status outputs and the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            partial    <= '0;
            vn_mode    <= 1'b0;
            pair_phase <= 1'b0;
            pair_first <= 1'b0;
            rand_out   <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (go) begin
                        state      <= ST_WARMUP;
                        cyc_cnt    <= '0;
                        bit_cnt    <= '0;
                        partial    <= '0;
                        vn_mode    <= vn_en;
                        pair_phase <= 1'b0;
                        pair_first <= 1'b0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    // Counter stops at WARMUP, so it never wraps.
                    if (cyc_cnt == CYC_W'(WARMUP)) begin
                        state <= ST_COLLECT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (vn_mode) begin
                        pair_phase <= ~pair_phase;
                        if (!pair_phase) begin
                            pair_first <= raw_bit;
                        end
                    end
                    // A health failure wins over a word completing this cycle.
                    if (health_fail) begin
                        state <= ST_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (word_full) begin
                            rand_out <= shift_next;
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            partial <= shift_next[OUT_W-1:1];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trng_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trng_collector
//  Description : Self-checking bench for trng_collector (OUT_W=8, NSRC=2,
//                WARMUP=4, REP_LIMIT=6). Expected words are queued when a
//                request is issued and compared when done or fail rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_collector;

    localparam int OUT_W     = 8;
    localparam int NSRC      = 2;
    localparam int WARMUP    = 4;
    localparam int REP_LIMIT = 6;

    // Edge index (go edge = 0) of the first COLLECT edge.
    localparam int FIRST_COL = WARMUP + 2;
    // Raw bit seen at a COLLECT edge was driven 3 edges earlier.
    localparam int PIPE_OFS  = FIRST_COL - 3;

    localparam int M_ZERO    = 0;
    localparam int M_ALT     = 1;
    localparam int M_ALT_INV = 2;
    localparam int M_VN      = 3;
    localparam int M_PRIO    = 4;

    typedef struct packed {
        logic [OUT_W-1:0] word;
        logic             fail;
        logic [31:0]      lat;
    } exp_t;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             go     = 1'b0;
    logic             vn_en  = 1'b0;
    logic [NSRC-1:0]  ent_in = '0;
    logic [OUT_W-1:0] rand_out;
    logic             done;
    logic             busy;
    logic             fail;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    int   mode     = M_ZERO;
    exp_t exp_q[$];

    trng_collector #(
        .OUT_W     (OUT_W),
        .NSRC      (NSRC),
        .WARMUP    (WARMUP),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .vn_en    (vn_en),
        .ent_in   (ent_in),
        .rand_out (rand_out),
        .done     (done),
        .busy     (busy),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Raw bit wanted at collect index j for each stimulus mode.
    function automatic logic raw_for(input int m, input int j);
        logic [7:0] vn_pat;
        int         jj;
        vn_pat = 8'b1110_0001;   // pairs 10,00,01,11 starting at bit 0
        jj     = j + 64;
        case (m)
            M_ZERO:    return 1'b0;
            M_ALT:     return (jj % 2) == 0;
            M_ALT_INV: return (jj % 2) != 0;
            M_VN:      return vn_pat[jj % 8];
            M_PRIO:    return j < 2;
            default:   return 1'b0;
        endcase
    endfunction

    // Drive ent_in for the next edge; the two sources XOR to the raw bit.
    task automatic drive_ent();
        logic r;
        logic x;
        r = raw_for(mode, edge_n + 1 - 4 + 3 - PIPE_OFS);
        x = (mode == M_ZERO) ? 1'b0 : 1'($urandom_range(0, 1));
        ent_in = {r ^ x, x};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        drive_ent();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request; go stays high for hold extra edges after acceptance.
    task automatic start_req(input int m, input logic vn, input logic [OUT_W-1:0] word,
                             input logic f, input int lat, input int hold);
        exp_t e;
        e.word = word;
        e.fail = f;
        e.lat  = 32'(lat);
        exp_q.push_back(e);
        mode   = m;
        vn_en  = vn;
        go     = 1'b1;
        edge_n = -1;
        drive_ent();
        tick();
        chk("busy_after_go", busy, 1);
        chk("done_cleared_on_go", done, 0);
        chk("fail_cleared_on_go", fail, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("busy_go_held", busy, 1);
        end
        go = 1'b0;
    endtask

    task automatic wait_result();
        exp_t e;
        int   k;
        k = 0;
        while (!(done || fail) && (k < 300)) begin
            tick();
            k++;
        end
        chk("result_within_budget", 32'(done || fail), 1);
        chk("scoreboard_not_empty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("latency_edges", edge_n, e.lat);
            chk("done_level", done, !e.fail);
            chk("fail_level", fail, e.fail);
            chk("rand_out", rand_out, e.word);
            chk("busy_after_end", busy, 0);
        end
    endtask

    // Linear directed sequence.
    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_rand_out", rand_out, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fail", fail, 0);
        rst_n = 1'b1;
        tick();

        // Constant-zero sources: sixth identical collected bit trips the test.
        start_req(M_ZERO, 1'b0, 8'h00, 1'b1, FIRST_COL + REP_LIMIT - 1, 0);
        wait_result();
        repeat (3) tick();
        chk("fail_is_level", fail, 1);

        // Alternating 1,0,... : first collected bit is 1.
        start_req(M_ALT, 1'b0, 8'h55, 1'b0, 1 + WARMUP + OUT_W, 0);
        wait_result();

        // Debiased: pairs 10,00,01,11 accept 1 then 0; eighth accepted pair
        // is pair index 14, i.e. 30 collect edges.
        start_req(M_VN, 1'b1, 8'h55, 1'b0, FIRST_COL + 29, 0);
        wait_result();

        // Six zeros ending exactly on the eighth bit: failure wins, word kept.
        start_req(M_PRIO, 1'b0, 8'h55, 1'b1, 1 + WARMUP + OUT_W, 0);
        wait_result();

        // go held through busy must not restart the request.
        start_req(M_ALT, 1'b0, 8'h55, 1'b0, 1 + WARMUP + OUT_W, 8);
        wait_result();
        repeat (2) tick();
        chk("done_is_level", done, 1);
        // Second go from DONE starts a new word.
        start_req(M_ALT_INV, 1'b0, 8'hAA, 1'b0, 1 + WARMUP + OUT_W, 0);
        wait_result();

        // Reset in the middle of COLLECT aborts the request.
        start_req(M_ALT, 1'b0, 8'h55, 1'b0, 1 + WARMUP + OUT_W, 0);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rand_out", rand_out, 0);
        chk("async_reset_done", done, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_fail", fail, 0);
        void'(exp_q.pop_front());
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_after_reset_done", done, 0);
        chk("idle_after_reset_busy", busy, 0);
        chk("idle_after_reset_rand_out", rand_out, 0);

        start_req(M_ALT_INV, 1'b0, 8'hAA, 1'b0, 1 + WARMUP + OUT_W, 0);
        wait_result();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation_time_limit observed=expired expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
